// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller, its pointers and the attached RAM.
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_AEMPTY_LVL = 4;
    // almost_full sits this many entries below completely full by default
    localparam int AFULL_MARGIN   = 4;

    // Default almost_full level for a given address width
    function automatic int afull_default(input int addr_width);
        return (2 ** addr_width) - AFULL_MARGIN;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Enable-driven wrapping counter used for the FIFO read and write pointers.
// The MSB acts as the wrap bit; the counter rolls over naturally at 2**WIDTH.
module fifo_ptr #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] value
);

    // Advance by one on each enabled cycle, clearing asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (en) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: owns the read/write pointers for an external synchronous
// RAM, generates its enables/addresses and reports occupancy and sticky errors.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_LVL  = (2 ** ADDR_WIDTH) - AFULL_MARGIN,
    parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic                rd_req,
    input  logic                clr_err,
    output logic                Write_EN,
    output logic                Read_EN,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_WIDTH:0] count,
    output logic                overflow,
    output logic                underflow
);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic                wr_acc;
    logic                rd_acc;

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_acc),
        .value (wptr)
    );

    fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_acc),
        .value (rptr)
    );

    // Occupancy flags and request acceptance, all derived from the registered pointers.
    // Acceptance is gated by rst_n so the RAM sees no enables while reset is held.
    always_comb begin
        count        = wptr - rptr;
        empty        = (wptr == rptr);
        full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                       (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
        almost_full  = (int'(count) >= AFULL_LVL);
        almost_empty = (int'(count) <= AEMPTY_LVL);
        wr_acc       = rst_n && wr_req && !full;
        rd_acc       = rst_n && rd_req && !empty;
        Write_EN     = wr_acc;
        Read_EN      = rd_acc;
        write_addr   = wptr[ADDR_WIDTH-1:0];
        read_addr    = rptr[ADDR_WIDTH-1:0];
    end

    // rd_valid follows an accepted read by one cycle, matching the RAM's registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
        end
    end

    // Sticky error flags; a clear in the same cycle beats a new error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a 4-entry configuration.
// A small reference model tracks pointers and flags; write addresses are queued
// as they are accepted and popped when the DUT issues the matching read.
module tb_fifo_ctrl;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_req;
    logic          rd_req;
    logic          clr_err;
    logic          Write_EN;
    logic          Read_EN;
    logic [AW-1:0] write_addr;
    logic [AW-1:0] read_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [AW:0]   m_wptr;
    logic [AW:0]   m_rptr;
    logic          m_rdv;
    logic          m_ovf;
    logic          m_unf;
    logic          exp_wen;
    logic          exp_ren;

    // values observed just before the active edge
    logic          obs_wen;
    logic          obs_ren;
    logic [AW-1:0] obs_waddr;
    logic [AW-1:0] obs_raddr;

    // scoreboard of written addresses awaiting a read
    logic [AW-1:0] sb_q[$];
    logic [AW-1:0] sb_addr;
    logic          sb_have;

    fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .AFULL_LVL  (3),
        .AEMPTY_LVL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .clr_err      (clr_err),
        .Write_EN     (Write_EN),
        .Read_EN      (Read_EN),
        .write_addr   (write_addr),
        .read_addr    (read_addr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [AW:0] m_count();
        return m_wptr - m_rptr;
    endfunction

    task automatic model_reset();
        m_wptr = '0;
        m_rptr = '0;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle of requests, capture pre-edge outputs, advance the model
    task automatic do_cycle(input logic wr, input logic rd, input logic clr);
        logic m_full_now;
        logic m_empty_now;
        @(negedge clk);
        wr_req  = wr;
        rd_req  = rd;
        clr_err = clr;
        #1;
        obs_wen   = Write_EN;
        obs_ren   = Read_EN;
        obs_waddr = write_addr;
        obs_raddr = read_addr;
        m_full_now  = (m_count() == 3'd4);
        m_empty_now = (m_wptr == m_rptr);
        exp_wen = wr && !m_full_now;
        exp_ren = rd && !m_empty_now;
        if (exp_wen) sb_q.push_back(m_wptr[AW-1:0]);
        sb_have = 1'b0;
        if (exp_ren && sb_q.size() > 0) begin
            sb_addr = sb_q.pop_front();
            sb_have = 1'b1;
        end
        @(posedge clk);
        if (exp_wen) m_wptr = m_wptr + 3'd1;
        if (exp_ren) m_rptr = m_rptr + 3'd1;
        m_rdv = exp_ren;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && m_full_now) m_ovf = 1'b1;
            if (rd && m_empty_now) m_unf = 1'b1;
        end
        #1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (Write_EN !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %b want 0", Write_EN); end
        checks++; if (Read_EN !== 1'b0) begin errors++; $display("[TB] FAIL reset_ren got %b want 0", Read_EN); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b%b want 11", empty, almost_empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b%b want 00", full, almost_full); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        checks++; if (write_addr !== 2'd0 || read_addr !== 2'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d/%0d want 0/0", write_addr, read_addr); end
        checks++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b%b want 000", rd_valid, overflow, underflow); end
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0);
            checks++; if (obs_wen !== 1'b1) begin errors++; $display("[TB] FAIL fill_wen[%0d] got %b want 1", i, obs_wen); end
            checks++; if (obs_waddr !== 2'(i)) begin errors++; $display("[TB] FAIL fill_waddr[%0d] got %0d want %0d", i, obs_waddr, i); end
            checks++; if (count !== m_count()) begin errors++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count, m_count()); end
            checks++; if (almost_full !== (m_count() >= 3'd3)) begin errors++; $display("[TB] FAIL fill_afull[%0d] got %b want %b", i, almost_full, (m_count() >= 3'd3)); end
        end
        checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("[TB] FAIL fill_full got %b/%0d want 1/4", full, count); end
        checks++; if (write_addr !== 2'd0) begin errors++; $display("[TB] FAIL fill_wrap_addr got %0d want 0", write_addr); end
        do_cycle(1'b1, 1'b0, 1'b0);
        checks++; if (obs_wen !== 1'b0) begin errors++; $display("[TB] FAIL ovf_wen got %b want 0", obs_wen); end
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_set got %b/%0d want 1/4", overflow, count); end
        do_cycle(1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_rw();
        do_cycle(1'b1, 1'b1, 1'b0);
        checks++; if (obs_ren !== 1'b1 || obs_wen !== 1'b0) begin errors++; $display("[TB] FAIL fullrw_en got ren=%b wen=%b want ren=1 wen=0", obs_ren, obs_wen); end
        checks++; if (!sb_have || obs_raddr !== sb_addr) begin errors++; $display("[TB] FAIL fullrw_raddr got %0d want %0d", obs_raddr, sb_addr); end
        checks++; if (count !== 3'd3 || full !== 1'b0) begin errors++; $display("[TB] FAIL fullrw_count got %0d/%b want 3/0", count, full); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_rdv got %b want 1", rd_valid); end
        do_cycle(1'b0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf got ovf=%b rdv=%b want 0/0", overflow, rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_cycle(1'b0, 1'b1, 1'b0);
        checks++; if (count !== 3'd2 || almost_empty !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start got %0d ae=%b af=%b want 2/0/0", count, almost_empty, almost_full); end
        for (int i = 0; i < 6; i++) begin
            do_cycle(1'b1, 1'b1, 1'b0);
            checks++; if (obs_wen !== 1'b1 || obs_ren !== 1'b1) begin errors++; $display("[TB] FAIL b2b_en[%0d] got wen=%b ren=%b want 1/1", i, obs_wen, obs_ren); end
            checks++; if (!sb_have || obs_raddr !== sb_addr) begin errors++; $display("[TB] FAIL b2b_raddr[%0d] got %0d want %0d", i, obs_raddr, sb_addr); end
            checks++; if (obs_waddr !== 2'(i)) begin errors++; $display("[TB] FAIL b2b_waddr[%0d] got %0d want %0d", i, obs_waddr, 2'(i)); end
            checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL b2b_count[%0d] got %0d want 2", i, count); end
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdv[%0d] got %b want 1", i, rd_valid); end
        end
        do_cycle(1'b0, 1'b1, 1'b0);
        checks++; if (count !== 3'd1 || almost_empty !== 1'b1 || empty !== 1'b0) begin errors++; $display("[TB] FAIL drain1 got %0d ae=%b e=%b want 1/1/0", count, almost_empty, empty); end
        checks++; if (!sb_have || obs_raddr !== sb_addr) begin errors++; $display("[TB] FAIL drain1_raddr got %0d want %0d", obs_raddr, sb_addr); end
        do_cycle(1'b0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0 || empty !== 1'b1 || rd_valid !== m_rdv) begin errors++; $display("[TB] FAIL drain0 got %0d e=%b rdv=%b want 0/1/%b", count, empty, rd_valid, m_rdv); end
    endtask

    task automatic test_underflow();
        do_cycle(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ren !== 1'b0) begin errors++; $display("[TB] FAIL unf_ren got %b want 0", obs_ren); end
        checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL unf_set got unf=%b rdv=%b want 1/0", underflow, rd_valid); end
        do_cycle(1'b0, 1'b1, 1'b1);
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL unf_clr_wins got %b want 0", underflow); end
        do_cycle(1'b1, 1'b1, 1'b0);
        checks++; if (obs_wen !== 1'b1 || obs_ren !== 1'b0) begin errors++; $display("[TB] FAIL emptyrw_en got wen=%b ren=%b want 1/0", obs_wen, obs_ren); end
        checks++; if (underflow !== m_unf || rd_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("[TB] FAIL emptyrw got unf=%b rdv=%b cnt=%0d want %b/0/1", underflow, rd_valid, count, m_unf); end
        do_cycle(1'b0, 1'b0, 1'b1);
        checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL emptyrw_clr got %b%b want 00", underflow, overflow); end
    endtask

    task automatic test_reset_mid();
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0);
        checks++; if (count !== 3'd3 || almost_full !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst got %0d af=%b want 3/1", count, almost_full); end
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        checks++; if (Read_EN !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_ren got %b want 1", Read_EN); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (empty !== 1'b1 || count !== 3'd0 || Read_EN !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid got e=%b cnt=%0d ren=%b want 1/0/0", empty, count, Read_EN); end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_rdv[%0d] got %b want 0", i, rd_valid); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(1'b0, 1'b0, 1'b0);
        checks++; if (rd_valid !== 1'b0 || count !== 3'd0 || read_addr !== 2'd0) begin errors++; $display("[TB] FAIL post_rst got rdv=%b cnt=%0d ra=%0d want 0/0/0", rd_valid, count, read_addr); end
        do_cycle(1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0);
        checks++; if (!sb_have || obs_raddr !== sb_addr || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_rd got ra=%0d rdv=%b want %0d/1", obs_raddr, rd_valid, sb_addr); end
    endtask

    initial begin
        $display("[TB] starting fifo_ctrl bench");
        test_reset();
        test_fill();
        test_full_rw();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        checks++; if (sb_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d want 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning RAM address width (depth = 2**ADDR_WIDTH).
REQ-002 SHALL have parameter AFULL_LVL, default 2**ADDR_WIDTH-4, meaning count at or above which almost_full asserts.
REQ-003 SHALL have parameter AEMPTY_LVL, default 4, meaning count at or below which almost_empty asserts.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n come first.
REQ-005 SHALL have port clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port wr_req  in  1  push request.
REQ-008 SHALL have port rd_req  in  1  pop request.
REQ-009 SHALL have port clr_err  in  1  synchronous clear of sticky error flags.
REQ-010 SHALL have port Write_EN  out  1  RAM write enable.
REQ-011 SHALL have port Read_EN  out  1  RAM read enable.
REQ-012 SHALL have port write_addr  out  ADDR_WIDTH  RAM write address.
REQ-013 SHALL have port read_addr  out  ADDR_WIDTH  RAM read address.
REQ-014 SHALL have port rd_valid  out  1  RAM DataOut holds popped word this cycle.
REQ-015 SHALL have port full, empty, almost_full, almost_empty  out  1 each  occupancy flags.
REQ-016 SHALL have port count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
REQ-017 SHALL have port overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 SHALL hold write and read pointers of ADDR_WIDTH+1 bits each; MSB is the wrap bit, low bits drive write_addr/read_addr directly.
REQ-019 SHALL accept a write when wr_req=1 and full=0; SHALL accept a read when rd_req=1 and empty=0.
REQ-020 SHALL drive Write_EN and Read_EN combinationally equal to write-accept and read-accept in the same cycle.
REQ-021 SHALL increment each pointer by 1 (modulo 2**(ADDR_WIDTH+1)) on the clock edge ending an accepted cycle; low bits wrap from 2**ADDR_WIDTH-1 to 0 and the wrap bit toggles.
REQ-022 SHALL assert rd_valid exactly one cycle after an accepted read, aligned with the RAM's registered DataOut; otherwise 0.
REQ-023 SHALL compute count = wptr - rptr (ADDR_WIDTH+1-bit modulo subtraction), combinational from registered pointers.
REQ-024 SHALL assert empty when wptr == rptr; full when low bits equal and wrap bits differ.
REQ-025 SHALL assert almost_full when count >= AFULL_LVL and almost_empty when count <= AEMPTY_LVL.
REQ-026 Simultaneous accepted read and write SHALL leave count unchanged and advance both pointers.
REQ-027 When full and both requests present: read accepted, write rejected, overflow set; new space is usable next cycle only.
REQ-028 When empty and both requests present: write accepted, read rejected, underflow set; rd_valid stays 0 next cycle.
REQ-029 overflow SHALL set on wr_req=1 while full; underflow SHALL set on rd_req=1 while empty; both hold until clr_err=1 (clr_err wins over a same-cycle set).

Reset
REQ-030 rst_n=0 SHALL asynchronously clear both pointers, rd_valid, overflow and underflow; resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0, count=0, addresses 0, Write_EN=0 and Read_EN=0 for the duration of reset.
REQ-031 Reset mid-operation SHALL discard all content; an rd_valid pending from the preceding cycle SHALL NOT assert after reset.

Structure
REQ-032 Package fifo_pkg SHALL hold default ADDR_WIDTH, DATA_WIDTH and threshold constants shared with the RAM and FIFO top.
REQ-033 A sub-module fifo_ptr (ADDR_WIDTH+1-bit enable-driven wrapping counter with async reset) SHALL be instantiated twice, once per pointer.

Verification (ADDR_WIDTH=2, AFULL_LVL=3, AEMPTY_LVL=1)
REQ-034 Reset -> empty=1, count=0, write_addr=read_addr=0, rd_valid=0, overflow=underflow=0.
REQ-035 4 writes then a 5th wr_req -> full=1, count=4, write_addr=0, Write_EN=0 on 5th, overflow=1 until clr_err.
REQ-036 From full, rd_req and wr_req together -> Read_EN=1, Write_EN=0, count=3 next cycle, rd_valid=1 one cycle after.
REQ-037 From count=2, simultaneous push/pop for 6 cycles -> count stays 2, addresses wrap 3->0, rd_valid every cycle after the first.
REQ-038 rd_req while empty -> Read_EN=0, underflow=1, rd_valid=0; clr_err -> underflow=0.
REQ-039 Assert rst_n=0 in the cycle after an accepted read at count=3 -> rd_valid never asserts, empty=1 immediately.
